// File: rtl/trdb_pkg.sv
// trdb_pkg: shared packet field widths, overflow marker constants and buffer types.
package trdb_pkg;
    localparam int PTYPE_LEN   = 2;
    localparam int P_LEN       = 7;
    localparam int PAYLOAD_LEN = 32;
    localparam logic [PTYPE_LEN-1:0] PTYPE_OVERFLOW = '1;
    localparam logic [P_LEN-1:0]     OVF_P_LEN      = P_LEN'(16);
    typedef enum logic {NORMAL, OVERFLOW} buf_state_e;
    typedef struct packed {
        logic [PTYPE_LEN-1:0]   ptype;
        logic [P_LEN-1:0]       plen;
        logic [PAYLOAD_LEN-1:0] payload;
    } trdb_packet_t;
endpackage

// File: rtl/trdb_fifo.sv
// trdb_fifo: power-of-two circular buffer with flush; push while full only lands with a pop.
module trdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push_ok, pop_ok;
    assign full_o  = count_o == CW'(DEPTH);
    assign empty_o = count_o == '0;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem[rptr];
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem[wptr] <= data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
            count_o <= count_o + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/trdb_packet_buffer.sv
// trdb_packet_buffer: non-stalling packet FIFO that drops on overflow and later
// inserts a marker packet carrying the number of packets lost.
module trdb_packet_buffer import trdb_pkg::*; #(
    parameter int DEPTH        = 8,
    parameter int DROP_CNT_LEN = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   pkt_valid_i,
    input  logic [PTYPE_LEN-1:0]   packet_type_i,
    input  logic [P_LEN-1:0]       packet_length_i,
    input  logic [PAYLOAD_LEN-1:0] packet_payload_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [PTYPE_LEN-1:0]   packet_type_o,
    output logic [P_LEN-1:0]       packet_length_o,
    output logic [PAYLOAD_LEN-1:0] packet_payload_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   overflow_o
);
    buf_state_e state;
    logic [DROP_CNT_LEN-1:0] drop_cnt, cnt_inc;
    trdb_packet_t wdata, rdata;
    logic full, empty, pop, slot, marker, push;
    assign pkt_valid_o = ~empty;
    assign pop         = pkt_valid_o & pkt_ready_i;
    assign slot        = ~full | pop;
    assign marker      = ~clear_i & (state == OVERFLOW) & slot;
    assign push        = marker | (~clear_i & (state == NORMAL) & pkt_valid_i & slot);
    assign cnt_inc     = &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
    assign wdata       = marker ? {PTYPE_OVERFLOW, OVF_P_LEN, PAYLOAD_LEN'(drop_cnt)}
                                : {packet_type_i, packet_length_i, packet_payload_i};
    assign {packet_type_o, packet_length_o, packet_payload_o} = empty ? '0 : rdata;
    assign overflow_o  = state == OVERFLOW;
    trdb_fifo #(.WIDTH($bits(trdb_packet_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(clear_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (wdata),
        .data_o (rdata),
        .full_o (full),
        .empty_o(empty),
        .count_o(fill_o)
    );
    // A packet arriving in the marker cycle is itself lost, so counting restarts at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= NORMAL;
            drop_cnt <= '0;
        end else if (clear_i) begin
            state    <= NORMAL;
            drop_cnt <= '0;
        end else if (marker) begin
            state    <= pkt_valid_i ? OVERFLOW : NORMAL;
            drop_cnt <= DROP_CNT_LEN'(pkt_valid_i);
        end else if (pkt_valid_i && (state == OVERFLOW || !slot)) begin
            state    <= OVERFLOW;
            drop_cnt <= cnt_inc;
        end
    end
endmodule

// File: tb/tb_trdb_packet_buffer.sv
// tb_trdb_packet_buffer: directed scenarios at DEPTH=4 with a queue scoreboard
// checked every cycle, plus a 2-bit drop-counter instance for saturation.
module tb_trdb_packet_buffer;
    import trdb_pkg::*;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [PTYPE_LEN-1:0]   t;
        logic [P_LEN-1:0]       l;
        logic [PAYLOAD_LEN-1:0] p;
    } exp_t;
    logic clk = 0, rst_n = 0, clear = 0, valid_in = 0, ready = 0;
    logic [PTYPE_LEN-1:0] type_in = '0;
    logic [P_LEN-1:0] len_in = '0;
    logic [PAYLOAD_LEN-1:0] pay_in = '0;
    logic valid_o, ovf_o, valid2, ovf2;
    logic [PTYPE_LEN-1:0] type_o, type2;
    logic [P_LEN-1:0] len_o, len2;
    logic [PAYLOAD_LEN-1:0] pay_o, pay2;
    logic [2:0] fill, fill2;
    int total = 0, bad = 0;
    exp_t q[$];
    exp_t e_head;
    logic m_ovf = 0, m_full, m_pop;
    logic [15:0] m_cnt = '0;

    always #5 clk = ~clk;

    trdb_packet_buffer #(.DEPTH(DEPTH), .DROP_CNT_LEN(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .pkt_valid_i(valid_in),
        .packet_type_i(type_in), .packet_length_i(len_in), .packet_payload_i(pay_in),
        .pkt_valid_o(valid_o), .pkt_ready_i(ready), .packet_type_o(type_o),
        .packet_length_o(len_o), .packet_payload_o(pay_o), .fill_o(fill), .overflow_o(ovf_o)
    );
    trdb_packet_buffer #(.DEPTH(DEPTH), .DROP_CNT_LEN(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .pkt_valid_i(valid_in),
        .packet_type_i(type_in), .packet_length_i(len_in), .packet_payload_i(pay_in),
        .pkt_valid_o(valid2), .pkt_ready_i(ready), .packet_type_o(type2),
        .packet_length_o(len2), .packet_payload_o(pay2), .fill_o(fill2), .overflow_o(ovf2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PTYPE_LEN-1:0] t, input logic [PAYLOAD_LEN-1:0] p);
        valid_in = v;
        type_in  = t;
        len_in   = v ? P_LEN'(5) : '0;
        pay_in   = p;
    endtask

    // Scoreboard: packets enter the expected queue as the buffer should accept them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
            m_cnt = '0;
        end else if (clear) begin
            q.delete();
            m_ovf = 0;
            m_cnt = '0;
        end else begin
            m_full = q.size() == DEPTH;
            m_pop  = q.size() != 0 && ready;
            if (m_pop) void'(q.pop_front());
            if (m_ovf && (!m_full || m_pop)) begin
                q.push_back('{PTYPE_OVERFLOW, OVF_P_LEN, PAYLOAD_LEN'(m_cnt)});
                if (valid_in) m_cnt = 16'd1;
                else begin
                    m_cnt = '0;
                    m_ovf = 0;
                end
            end else if (valid_in) begin
                if (!m_ovf && (!m_full || m_pop)) q.push_back('{type_in, len_in, pay_in});
                else begin
                    m_ovf = 1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            e_head = q.size() != 0 ? q[0] : '0;
            chk("sb_valid", valid_o, q.size() != 0);
            chk("sb_fill", fill, q.size());
            chk("sb_overflow", ovf_o, m_ovf);
            chk("sb_head", {type_o, len_o, pay_o}, e_head);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_pkt", {type_o, len_o, pay_o}, 0);
        #10 rst_n = 1;
        cyc();
        // streaming with ready high: one cycle latency, fill never above 1
        ready = 1;
        for (int t = 1; t <= 3; t++) begin
            drive(1, PTYPE_LEN'(t), 100 + t);
            cyc();
            chk("pass_type", type_o, t);
            chk("pass_payload", pay_o, 100 + t);
            chk("pass_fill", fill, 1);
        end
        drive(0, 0, 0);
        cyc();
        chk("pass_empty", valid_o, 0);
        chk("pass_zero", {type_o, len_o, pay_o}, 0);
        // six pushes into a stalled sink
        ready = 0;
        for (int i = 1; i <= 6; i++) begin
            drive(1, 1, i);
            cyc();
            chk("ovf_fill", fill, i > 4 ? 4 : i);
            chk("ovf_flag", ovf_o, i >= 5);
        end
        drive(0, 0, 0);
        ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", pay_o, i);
            cyc();
        end
        chk("marker_type", type_o, PTYPE_OVERFLOW);
        chk("marker_len", len_o, OVF_P_LEN);
        chk("marker_payload", pay_o, 2);
        chk("marker_ovf_clr", ovf_o, 0);
        cyc();
        chk("marker_empty", valid_o, 0);
        // push and pop together while full
        ready = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2, 10 + i);
            cyc();
        end
        drive(1, 2, 15);
        ready = 1;
        cyc();
        drive(0, 0, 0);
        chk("full_pp_fill", fill, 4);
        chk("full_pp_ovf", ovf_o, 0);
        for (int i = 12; i <= 15; i++) begin
            chk("full_pp_order", pay_o, i);
            cyc();
        end
        chk("full_pp_empty", valid_o, 0);
        // overflow with input every cycle: markers after the first carry 1
        ready = 0;
        for (int i = 1; i <= 7; i++) begin
            drive(1, 1, 20 + i);
            cyc();
        end
        ready = 1;
        drive(1, 1, 30);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("cont_ovf", ovf_o, 1);
            chk("cont_fill", fill, 4);
            chk("cont_head", pay_o, k <= 3 ? 21 + k : (k == 4 ? 3 : 1));
            chk("cont_type", type_o, k <= 3 ? 1 : PTYPE_OVERFLOW);
        end
        drive(0, 0, 0);
        n = 0;
        while (fill != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("cont_drain", fill, 0);
        chk("cont_ovf_end", ovf_o, 0);
        // clear beats a simultaneous push
        ready = 0;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 40 + i);
            cyc();
        end
        chk("clr_pre_fill", fill, 3);
        drive(1, 1, 99);
        clear = 1;
        cyc();
        clear = 0;
        drive(0, 0, 0);
        chk("clr_fill", fill, 0);
        chk("clr_valid", valid_o, 0);
        chk("clr_ovf", ovf_o, 0);
        // asynchronous reset mid-stream
        drive(1, 1, 44);
        cyc();
        drive(1, 1, 45);
        cyc();
        drive(0, 0, 0);
        #3 rst_n = 0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_fill", fill, 0);
        chk("arst_ovf", ovf_o, 0);
        chk("arst_pkt", {type_o, len_o, pay_o}, 0);
        @(posedge clk);
        #1;
        chk("arst_hold", {valid_o, fill, ovf_o}, 0);
        @(negedge clk);
        #1 rst_n = 1;
        drive(1, 1, 50);
        cyc();
        drive(0, 0, 0);
        chk("arst_first", pay_o, 50);
        chk("arst_first_fill", fill, 1);
        ready = 1;
        cyc();
        chk("arst_empty", valid_o, 0);
        // five drops: 16-bit counter reports 5, 2-bit counter saturates at 3
        ready = 0;
        for (int i = 1; i <= 9; i++) begin
            drive(1, 1, 60 + i);
            cyc();
        end
        drive(0, 0, 0);
        ready = 1;
        repeat (4) cyc();
        chk("sat_wide_payload", pay_o, 5);
        chk("sat_type", type2, PTYPE_OVERFLOW);
        chk("sat_len", len2, OVF_P_LEN);
        chk("sat_payload", pay2, 3);
        cyc();
        chk("sat_empty", valid_o, 0);
        chk("sat_empty2", valid2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
